// File: rtl/riscv_pkg.sv
// RV32I shared definitions: base opcodes and immediate formats.
// Used by decode, writeback and hazard logic.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: classifies the opcode and builds the
// sign-extended immediate; unknown opcodes are flagged illegal with imm 0.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] insn,
  output logic [31:0] imm,
  output imm_fmt_e    fmt,
  output logic        illegal
);

  logic [6:0] opcode;
  assign opcode = insn[6:0];

  always_comb begin
    fmt     = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = IMM_I;
      OPC_STORE:                                  fmt = IMM_S;
      OPC_BRANCH:                                 fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
      OPC_JAL:                                    fmt = IMM_J;
      OPC_OP, OPC_MISC_MEM:                       fmt = IMM_NONE;
      default:                                    illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{insn[31]}}, insn[31:20]};
      IMM_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B: imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_U: imm = {insn[31:12], 12'b0};
      IMM_J: imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: registered decode bundle over valid/ready, register file
// address mux, and same-edge writeback bypass into the operand data.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_insn,
  input  logic            flush,
  output logic [4:0]      rf_addr_rs1,
  output logic [4:0]      rf_addr_rs2,
  input  logic [XLEN-1:0] rf_data_rs1,
  input  logic [XLEN-1:0] rf_data_rs2,
  input  logic            wb_write_enable,
  input  logic [4:0]      wb_addr_rd,
  input  logic [XLEN-1:0] wb_data_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_insn,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_funct7_b5,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic            out_illegal
);

  logic        accept;
  logic [31:0] dec_imm;
  imm_fmt_e    dec_fmt;
  logic        dec_illegal;
  logic        hit_rs1, hit_rs2;
  logic [XLEN-1:0] byp_rs1, byp_rs2;

  imm_gen u_imm_gen (
    .insn    (in_insn),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Re-read the held sources every cycle so the register file keeps them fresh.
  assign rf_addr_rs1 = accept ? in_insn[19:15] : out_insn[19:15];
  assign rf_addr_rs2 = accept ? in_insn[24:20] : out_insn[24:20];

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_insn      <= '0;
      out_rd        <= '0;
      out_funct3    <= '0;
      out_funct7_b5 <= 1'b0;
      out_imm       <= '0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_insn      <= in_insn;
      out_rd        <= (dec_fmt == IMM_S || dec_fmt == IMM_B) ? 5'd0 : in_insn[11:7];
      out_funct3    <= in_insn[14:12];
      out_funct7_b5 <= in_insn[30];
      out_imm       <= dec_imm;
      out_illegal   <= dec_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // The register file returns the pre-write value for a same-edge write; catch it here.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_rs1 <= 1'b0;
      hit_rs2 <= 1'b0;
      byp_rs1 <= '0;
      byp_rs2 <= '0;
    end else begin
      hit_rs1 <= wb_write_enable && (wb_addr_rd != 5'd0) && (wb_addr_rd == rf_addr_rs1);
      hit_rs2 <= wb_write_enable && (wb_addr_rd != 5'd0) && (wb_addr_rd == rf_addr_rs2);
      byp_rs1 <= wb_data_rd;
      byp_rs2 <= wb_data_rd;
    end
  end

  assign out_rs1_data = (BYPASS_EN && hit_rs1) ? byp_rs1 : rf_data_rs1;
  assign out_rs2_data = (BYPASS_EN && hit_rs2) ? byp_rs2 : rf_data_rs2;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a small registered-read register file
// model that returns the old value on a same-edge write.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_insn;
  logic        flush;
  logic [4:0]  rf_addr_rs1, rf_addr_rs2;
  logic [31:0] rf_data_rs1, rf_data_rs2;
  logic        wb_write_enable;
  logic [4:0]  wb_addr_rd;
  logic [31:0] wb_data_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_insn, out_imm, out_rs1_data, out_rs2_data;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic        out_funct7_b5, out_illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];

  always #5 clock = ~clock;

  decode_stage #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn),
    .flush(flush),
    .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
    .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2),
    .wb_write_enable(wb_write_enable), .wb_addr_rd(wb_addr_rd), .wb_data_rd(wb_data_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_insn(out_insn), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_funct7_b5(out_funct7_b5), .out_imm(out_imm),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_illegal(out_illegal)
  );

  // Register file model: read data registered, old value on same-edge write.
  always @(posedge clock) begin
    rf_data_rs1 <= regs[rf_addr_rs1];
    rf_data_rs2 <= regs[rf_addr_rs2];
    if (wb_write_enable && wb_addr_rd != 5'd0) regs[wb_addr_rd] <= wb_data_rd;
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  localparam logic [31:0] ADDI  = 32'hFFF08293; // addi x5,x1,-1
  localparam logic [31:0] BEQ   = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] LUI   = 32'h123451B7; // lui x3,0x12345
  localparam logic [31:0] SW    = 32'hFE20AC23; // sw x2,-8(x1)
  localparam logic [31:0] ADD   = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] ADD0  = 32'h002001B3; // add x3,x0,x2

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h11111111 * i;
    reset = 1'b1; in_valid = 1'b1; in_pc = 32'h0; in_insn = ADDI; flush = 1'b0;
    wb_write_enable = 1'b0; wb_addr_rd = '0; wb_data_rd = '0; out_ready = 1'b1;

    // Reset with a valid input pending
    cyc(); cyc();
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_imm", out_imm, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0; in_valid = 1'b0;
    cyc();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // I-type
    in_valid = 1'b1; in_pc = 32'h100; in_insn = ADDI;
    cyc(); in_valid = 1'b0; #1;
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_rd", {27'd0, out_rd}, 32'd5);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_rs1", out_rs1_data, 32'h11111111);
    chk("addi_illegal", {31'd0, out_illegal}, 32'd0);
    cyc();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // B-type, then U-type back to back, then S-type
    in_valid = 1'b1; in_pc = 32'h104; in_insn = BEQ;
    cyc(); #1;
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_rd", {27'd0, out_rd}, 32'd0);
    in_pc = 32'h108; in_insn = LUI;
    cyc(); #1;
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_rd", {27'd0, out_rd}, 32'd3);
    in_pc = 32'h10C; in_insn = SW;
    cyc(); #1;
    chk("sw_imm", out_imm, 32'hFFFFFFF8);
    chk("sw_rd", {27'd0, out_rd}, 32'd0);
    chk("sw_funct3", {29'd0, out_funct3}, 32'd2);

    // Bypass: same-edge write to x1
    in_pc = 32'h110; in_insn = ADD;
    wb_write_enable = 1'b1; wb_addr_rd = 5'd1; wb_data_rd = 32'hDEADBEEF;
    cyc(); in_valid = 1'b0; wb_write_enable = 1'b0; #1;
    chk("byp_rs1", out_rs1_data, 32'hDEADBEEF);
    chk("byp_rs2", out_rs2_data, 32'h22222222);
    cyc();

    // Same-edge write to x0 never forwards
    in_valid = 1'b1; in_pc = 32'h114; in_insn = ADD0;
    wb_write_enable = 1'b1; wb_addr_rd = 5'd0; wb_data_rd = 32'hCAFEF00D;
    cyc(); in_valid = 1'b0; wb_write_enable = 1'b0; #1;
    chk("x0_rs1", out_rs1_data, 32'd0);
    cyc();

    // Backpressure: hold bundle while x2 is written
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200; in_insn = ADD;
    cyc(); in_pc = 32'h204; in_insn = LUI; #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_rs1_fresh", out_rs1_data, 32'hDEADBEEF);
    wb_write_enable = 1'b1; wb_addr_rd = 5'd2; wb_data_rd = 32'h55;
    cyc(); wb_write_enable = 1'b0; #1;
    chk("bp1_rs2", out_rs2_data, 32'h55);
    chk("bp1_pc", out_pc, 32'h200);
    cyc(); #1;
    chk("bp2_rs2", out_rs2_data, 32'h55);
    chk("bp2_insn", out_insn, ADD);
    cyc(); #1;
    chk("bp3_pc", out_pc, 32'h200);
    chk("bp3_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp3_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1; #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    cyc(); #1;
    chk("bp_next_insn", out_insn, LUI);
    chk("bp_next_pc", out_pc, 32'h204);

    // Flush with a pending accept
    in_pc = 32'h300; in_insn = ADDI; flush = 1'b1; #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    cyc(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    cyc(); #1;
    chk("flush_valid2", {31'd0, out_valid}, 32'd0);

    // Illegal opcode still flows through
    in_valid = 1'b1; in_pc = 32'h400; in_insn = 32'h0;
    cyc(); in_valid = 1'b0; #1;
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_imm", out_imm, 32'd0);
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
